// File: rtl/bool_sweep_pkg.sv
// ---------------------------------------------------------------------------
// bool_sweep_pkg
// Shared definitions for the boolean truth-table sweep controller:
//   - sweep_state_e : controller FSM states
//   - NUM_VECTORS   : number of input vectors in a 4-input sweep
//   - IDX_W         : width of the vector index / abcd drive
//   - LAST_IDX      : index of the final vector in a sweep
//   - is_busy_state : decode of the states in which a sweep is running
//   - bit_differs   : single-bit compare of a captured value with golden
// ---------------------------------------------------------------------------
package bool_sweep_pkg;

   localparam int NUM_VECTORS = 16;
   localparam int IDX_W       = 4;

   localparam logic [IDX_W-1:0] LAST_IDX = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_SAMPLE = 2'b10,
      ST_DONE   = 2'b11
   } sweep_state_e;

   function automatic logic is_busy_state(input sweep_state_e st);
      return (st == ST_SETTLE) || (st == ST_SAMPLE);
   endfunction

   function automatic logic bit_differs(input logic captured, input logic golden);
      return captured ^ golden;
   endfunction

endpackage

// File: rtl/bool_sweep_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// Down-counter that times how long an input vector is held before sampling.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load count_r with load_val (has priority over tick)
//   load_val : value loaded on load
//   tick     : decrement by one, saturating at zero
//   zero     : high while the count is zero
// ---------------------------------------------------------------------------
module settle_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             tick,
   output logic             zero
);

   logic [CNT_W-1:0] count_r;

   // Countdown register: load wins over tick, never wraps below zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (tick && (count_r != '0)) begin
         count_r <= count_r - 1'b1;
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = (count_r == '0);

endmodule

// File: rtl/bool_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// bool_sweep_ctrl
// Drives all 16 input vectors into a 4-input boolean block, waits
// SETTLE_CYCLES per vector, captures F into a truth table and compares it
// against a golden table.
//   clk         : clock, all state updates on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : request a sweep (only honoured in IDLE, abort has priority)
//   abort       : stop a running sweep, partial results are kept
//   expected    : golden truth table, bit i = expected F for vector i
//   f_in        : F output of the block under sweep
//   abcd        : vector driven to the block (bit3=A .. bit0=D)
//   busy        : sweep in progress (SETTLE or SAMPLE)
//   done        : one-cycle pulse at sweep completion
//   truth_table : captured F, bit i = F for vector i
//   mismatch    : sticky, some captured bit differed from expected
//   first_fail  : lowest mismatching vector index (valid with mismatch)
// ---------------------------------------------------------------------------
module bool_sweep_ctrl
   import bool_sweep_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_VECTORS-1:0] expected,
   input  logic                   f_in,
   output logic [IDX_W-1:0]       abcd,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_VECTORS-1:0] truth_table,
   output logic                   mismatch,
   output logic [IDX_W-1:0]       first_fail
);

   // The timer reaches zero after LOAD_VAL ticks, so SETTLE spans
   // exactly SETTLE_CYCLES cycles including the cycle it is entered in.
   localparam logic [IDX_W-1:0] LOAD_VAL = IDX_W'(SETTLE_CYCLES - 1);

   sweep_state_e           state_r;
   sweep_state_e           state_s;
   logic [IDX_W-1:0]       idx_r;
   logic                   busy_r;
   logic                   done_r;
   logic [NUM_VECTORS-1:0] tt_r;
   logic                   mm_r;
   logic [IDX_W-1:0]       ff_r;

   logic                   accept_s;
   logic                   advance_s;
   logic                   capture_s;
   logic                   load_s;
   logic                   tick_s;
   logic                   zero_s;

   settle_timer #(
      .CNT_W (IDX_W)
   ) u_settle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s),
      .load_val (LOAD_VAL),
      .tick     (tick_s),
      .zero     (zero_s)
   );

   // Next-state and control decode for the sweep FSM.
   always_comb begin
      state_s   = state_r;
      accept_s  = 1'b0;
      advance_s = 1'b0;
      capture_s = 1'b0;
      load_s    = 1'b0;
      tick_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start && !abort) begin
               state_s  = ST_SETTLE;
               accept_s = 1'b1;
               load_s   = 1'b1;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else if (zero_s) begin
               state_s = ST_SAMPLE;
            end else begin
               state_s = ST_SETTLE;
               tick_s  = 1'b1;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               state_s = ST_IDLE;
            end else begin
               capture_s = 1'b1;
               if (idx_r == LAST_IDX) begin
                  // abcd is left at the last vector rather than wrapping
                  state_s = ST_DONE;
               end else begin
                  state_s   = ST_SETTLE;
                  advance_s = 1'b1;
                  load_s    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // FSM state plus busy/done, registered from the next state so the
   // outputs line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= is_busy_state(state_s);
         done_r  <= (state_s == ST_DONE);
      end
   end

   // Vector index; it is also the abcd drive, so it holds in IDLE/DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r <= '0;
      end else if (accept_s) begin
         idx_r <= '0;
      end else if (advance_s) begin
         idx_r <= idx_r + 1'b1;
      end else begin
         idx_r <= idx_r;
      end
   end

   // Result capture: cleared on an accepted start, otherwise held so
   // partial results survive an abort and final results survive DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_r <= '0;
         mm_r <= 1'b0;
         ff_r <= '0;
      end else if (accept_s) begin
         tt_r <= '0;
         mm_r <= 1'b0;
         ff_r <= '0;
      end else if (capture_s) begin
         tt_r[idx_r] <= f_in;
         if (bit_differs(f_in, expected[idx_r]) && !mm_r) begin
            mm_r <= 1'b1;
            ff_r <= idx_r;
         end else begin
            mm_r <= mm_r;
            ff_r <= ff_r;
         end
      end else begin
         tt_r <= tt_r;
         mm_r <= mm_r;
         ff_r <= ff_r;
      end
   end

   assign abcd        = idx_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign truth_table = tt_r;
   assign mismatch    = mm_r;
   assign first_fail  = ff_r;

endmodule

// File: doc/bool_sweep_ctrl.md
BOOL_SWEEP_CTRL -- requirements
Module: bool_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the clock cycles each input vector is held before F is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 expected  input  16  golden truth table; bit i is the expected F for vector i.
REQ-007 f_in  input  1  F output of the boolean block under sweep.
REQ-008 abcd  output  4  drive to the block; bit3=A, bit2=B, bit1=C, bit0=D.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 truth_table  output  16  captured F; bit i holds F for vector i.
REQ-012 mismatch  output  1  sticky, high if any captured bit differs from expected.
REQ-013 first_fail  output  4  lowest vector index that mismatched; valid when mismatch=1.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, SAMPLE and DONE.
REQ-015 In IDLE with start=1 and abort=0, the controller SHALL clear truth_table, mismatch and first_fail, set index and abcd to 0, load the settle counter, and enter SETTLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles with abcd stable, then enter SAMPLE.
REQ-017 SAMPLE SHALL last one cycle and write f_in to truth_table[index].
REQ-018 If f_in != expected[index] in SAMPLE and mismatch=0, mismatch SHALL set and first_fail SHALL load index.
REQ-019 From SAMPLE with index<15, index and abcd SHALL increment by 1 and the FSM SHALL re-enter SETTLE; with index=15 it SHALL enter DONE without wrapping abcd.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle beginning 16*(SETTLE_CYCLES+1) rising edges after the edge that accepted start.
REQ-022 busy SHALL be 1 in SETTLE and SAMPLE and 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in SETTLE, SAMPLE and DONE, and SHALL NOT be queued.
REQ-024 abort=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge, with no done pulse and no capture in that cycle; truth_table, mismatch and first_fail SHALL hold their partial values.
REQ-025 When abort and start are both 1 in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-026 abcd SHALL hold its last value in IDLE and DONE.
REQ-027 truth_table, mismatch and first_fail SHALL hold their values after DONE until the next accepted start.
REQ-028 expected SHALL be required stable only during the SAMPLE cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, abcd=0, busy=0, done=0, truth_table=0, mismatch=0, first_fail=0, index=0 and settle count=0, including in the middle of a sweep.
REQ-030 The first accepted start SHALL be the first edge after rst_n deasserts on which start=1.

Structure
REQ-031 Shared package bool_sweep_pkg SHALL hold the FSM state enum, NUM_VECTORS=16 and IDX_W=4.
REQ-032 The settle countdown SHALL be a sub-module, settle_timer, with load, tick and zero ports.
REQ-033 The complete controller SHALL be implemented in approximately 120-250 lines of RTL.

Verification
REQ-034 With SETTLE_CYCLES=1, f_in = A&B | C&D and expected=16'hF888, start -> done at edge 32, truth_table=16'hF888, mismatch=0.
REQ-035 Same model with expected=16'hF88C -> mismatch=1, first_fail=2, truth_table=16'hF888.
REQ-036 SETTLE_CYCLES=3 -> each abcd value held for 3 cycles, 4 cycles per vector in total, done at edge 64.
REQ-037 abort asserted at edge 9 with SETTLE_CYCLES=1 -> busy=0 from edge 10, no done, truth_table[3:0] captured and bits 15:4 still 0.
REQ-038 rst_n=0 mid-sweep at vector 7 -> all outputs 0 immediately, without waiting for clk; a new start then runs a full sweep.
REQ-039 start held high for 40 cycles -> exactly one sweep per IDLE entry, no start accepted while busy, and a second sweep begins on the edge after DONE.
